// File: rtl/msrh_lsu_ld_pipe_gen.sv
// Four-stage (EX0-EX3) load pipeline for one LSU lane: arbitration, address/TLB, L1D check, writeback.
// Optional performance counters are built when MSRH_LSU_LD_PIPE_PERF_EN is defined.
module msrh_lsu_ld_pipe_gen #(
   parameter int unsigned XLEN_W  = 64,
   parameter int unsigned VADDR_W = 39,
   parameter int unsigned PADDR_W = 56,
   parameter int unsigned LINE_W  = 128,
   parameter int unsigned RNID_W  = 7,
   parameter int unsigned TAG_W   = 5
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rs_valid,
   input  logic [XLEN_W-1:0]  i_rs_rs1,
   input  logic [11:0]        i_rs_imm,
   input  logic [1:0]         i_rs_size,
   input  logic               i_rs_signed,
   input  logic [RNID_W-1:0]  i_rs_rnid,
   input  logic [TAG_W-1:0]   i_rs_tag,
   input  logic               i_rp_valid,
   input  logic [XLEN_W-1:0]  i_rp_rs1,
   input  logic [11:0]        i_rp_imm,
   input  logic [1:0]         i_rp_size,
   input  logic               i_rp_signed,
   input  logic [RNID_W-1:0]  i_rp_rnid,
   input  logic [TAG_W-1:0]   i_rp_tag,
   output logic               o_ex0_conflict,
   output logic [TAG_W-1:0]   o_ex0_conflict_tag,
   input  logic               i_flush,
   output logic [VADDR_W-1:0] o_tlb_vaddr,
   input  logic               i_tlb_miss,
   input  logic [PADDR_W-1:0] i_tlb_paddr,
   output logic               o_l1d_valid,
   output logic [PADDR_W-1:0] o_l1d_paddr,
   input  logic               i_l1d_hit,
   input  logic               i_l1d_miss,
   input  logic               i_l1d_conflict,
   input  logic [LINE_W-1:0]  i_l1d_data,
   output logic               o_ex1_upd_valid,
   output logic [TAG_W-1:0]   o_ex1_upd_tag,
   output logic [1:0]         o_ex1_upd_haz,
   output logic               o_ex2_upd_valid,
   output logic [TAG_W-1:0]   o_ex2_upd_tag,
   output logic [1:0]         o_ex2_upd_haz,
   output logic [PADDR_W-1:0] o_ex2_miss_paddr,
   output logic               o_ex3_wr_valid,
   output logic [RNID_W-1:0]  o_ex3_wr_rnid,
   output logic [XLEN_W-1:0]  o_ex3_wr_data,
   output logic               o_ex3_done
`ifdef MSRH_LSU_LD_PIPE_PERF_EN
   ,
   output logic [31:0]        o_perf_done,
   output logic [31:0]        o_perf_tlb_miss,
   output logic [31:0]        o_perf_l1d_miss,
   output logic [31:0]        o_perf_conflict
`endif
);

   localparam int unsigned OFF_W = $clog2(LINE_W / 8);
   localparam logic [PADDR_W-1:0] LINE_MASK = ~PADDR_W'((64'd1 << OFF_W) - 64'd1);

   localparam logic [1:0] HAZ_NONE         = 2'd0;
   localparam logic [1:0] HAZ_TLB_MISS     = 2'd1;
   localparam logic [1:0] HAZ_MISALIGN     = 2'd2;
   localparam logic [1:0] HAZ_L1D_MISS     = 2'd1;
   localparam logic [1:0] HAZ_L1D_CONFLICT = 2'd2;

   typedef struct packed {
      logic [VADDR_W-1:0] base;
      logic [11:0]        imm;
      logic [1:0]         size;
      logic               sgn;
      logic [RNID_W-1:0]  rnid;
      logic [TAG_W-1:0]   tag;
   } ld_op_t;

   ld_op_t              ex0_op;
   logic                ex1_valid;
   ld_op_t              ex1_op;
   logic [VADDR_W-1:0]  ex1_vaddr;
   logic                ex1_misalign;
   logic [1:0]          ex1_haz;
   logic                ex1_adv;

   logic                ex2_valid;
   logic [PADDR_W-1:0]  ex2_paddr;
   logic [1:0]          ex2_size;
   logic                ex2_sgn;
   logic [RNID_W-1:0]   ex2_rnid;
   logic [TAG_W-1:0]    ex2_tag;
   logic [1:0]          ex2_haz;
   logic                ex2_adv;
   logic [OFF_W-1:0]    ex2_byte_off;
   logic [XLEN_W-1:0]   ex2_raw;
   logic [XLEN_W-1:0]   ex2_ext;
   logic                ex2_msb;
   logic [XLEN_W-1:0]   ex2_data;

   logic                ex3_valid;
   logic [RNID_W-1:0]   ex3_rnid;
   logic [XLEN_W-1:0]   ex3_data;

   // EX0: replay wins; a coincident RS issue is dropped and reported
   always_comb begin
      ex0_op.base = VADDR_W'(i_rs_rs1);
      ex0_op.imm  = i_rs_imm;
      ex0_op.size = i_rs_size;
      ex0_op.sgn  = i_rs_signed;
      ex0_op.rnid = i_rs_rnid;
      ex0_op.tag  = i_rs_tag;
      if (i_rp_valid) begin
         ex0_op.base = VADDR_W'(i_rp_rs1);
         ex0_op.imm  = i_rp_imm;
         ex0_op.size = i_rp_size;
         ex0_op.sgn  = i_rp_signed;
         ex0_op.rnid = i_rp_rnid;
         ex0_op.tag  = i_rp_tag;
      end
   end

   assign o_ex0_conflict     = i_rs_valid & i_rp_valid;
   assign o_ex0_conflict_tag = i_rs_tag;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ex1_valid <= 1'b0;
         ex1_op    <= '0;
      end else begin
         ex1_valid <= (i_rs_valid | i_rp_valid) & ~i_flush;
         ex1_op    <= ex0_op;
      end
   end

   // EX1: address generation, alignment and TLB hazard classification
   always_comb begin
      ex1_vaddr    = ex1_op.base + VADDR_W'($signed(ex1_op.imm));
      ex1_misalign = 1'b0;
      case (ex1_op.size)
         2'd1:    ex1_misalign = ex1_vaddr[0];
         2'd2:    ex1_misalign = |ex1_vaddr[1:0];
         2'd3:    ex1_misalign = (|ex1_vaddr[2:0]) | (XLEN_W < 64);
         default: ex1_misalign = 1'b0;
      endcase
      ex1_haz = HAZ_NONE;
      if (ex1_valid) begin
         if (i_tlb_miss)        ex1_haz = HAZ_TLB_MISS;
         else if (ex1_misalign) ex1_haz = HAZ_MISALIGN;
      end
      ex1_adv = ex1_valid & (ex1_haz == HAZ_NONE) & ~i_flush;
   end

   assign o_tlb_vaddr     = ex1_vaddr;
   assign o_l1d_valid     = ex1_adv;
   assign o_l1d_paddr     = ex1_valid ? (i_tlb_paddr & LINE_MASK) : '0;
   assign o_ex1_upd_valid = ex1_valid;
   assign o_ex1_upd_tag   = ex1_op.tag;
   assign o_ex1_upd_haz   = ex1_haz;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ex2_valid <= 1'b0;
         ex2_paddr <= '0;
         ex2_size  <= '0;
         ex2_sgn   <= 1'b0;
         ex2_rnid  <= '0;
         ex2_tag   <= '0;
      end else begin
         ex2_valid <= ex1_adv;
         ex2_paddr <= i_tlb_paddr;
         ex2_size  <= ex1_op.size;
         ex2_sgn   <= ex1_op.sgn;
         ex2_rnid  <= ex1_op.rnid;
         ex2_tag   <= ex1_op.tag;
      end
   end

   // EX2: cache result classification and size-aligned extraction from the line
   always_comb begin
      ex2_haz = HAZ_NONE;
      if (ex2_valid) begin
         if (i_l1d_conflict)  ex2_haz = HAZ_L1D_CONFLICT;
         else if (i_l1d_miss) ex2_haz = HAZ_L1D_MISS;
      end
      ex2_adv      = ex2_valid & i_l1d_hit & (ex2_haz == HAZ_NONE) & ~i_flush;
      ex2_byte_off = ex2_paddr[OFF_W-1:0];
      ex2_raw      = XLEN_W'(i_l1d_data >> {ex2_byte_off, 3'b000});
      case (ex2_size)
         2'd0: begin
            ex2_data = XLEN_W'(ex2_raw[7:0]);
            ex2_msb  = ex2_raw[7];
            ex2_ext  = {XLEN_W{1'b1}} << 8;
         end
         2'd1: begin
            ex2_data = XLEN_W'(ex2_raw[15:0]);
            ex2_msb  = ex2_raw[15];
            ex2_ext  = {XLEN_W{1'b1}} << 16;
         end
         2'd2: begin
            ex2_data = XLEN_W'(ex2_raw[31:0]);
            ex2_msb  = ex2_raw[31];
            ex2_ext  = {XLEN_W{1'b1}} << 32;
         end
         default: begin
            ex2_data = ex2_raw;
            ex2_msb  = 1'b0;
            ex2_ext  = '0;
         end
      endcase
      if (ex2_sgn & ex2_msb) ex2_data = ex2_data | ex2_ext;
   end

   assign o_ex2_upd_valid  = ex2_valid;
   assign o_ex2_upd_tag    = ex2_tag;
   assign o_ex2_upd_haz    = ex2_haz;
   assign o_ex2_miss_paddr = ex2_paddr;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ex3_valid <= 1'b0;
         ex3_rnid  <= '0;
         ex3_data  <= '0;
      end else begin
         ex3_valid <= ex2_adv;
         ex3_rnid  <= ex2_rnid;
         ex3_data  <= ex2_data;
      end
   end

   assign o_ex3_wr_valid = ex3_valid;
   assign o_ex3_done     = ex3_valid;
   assign o_ex3_wr_rnid  = ex3_rnid;
   assign o_ex3_wr_data  = ex3_data;

`ifdef MSRH_LSU_LD_PIPE_PERF_EN
   // Saturating event counters
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_perf_done     <= '0;
         o_perf_tlb_miss <= '0;
         o_perf_l1d_miss <= '0;
         o_perf_conflict <= '0;
      end else begin
         if (ex3_valid && (o_perf_done != '1))
            o_perf_done <= o_perf_done + 32'd1;
         if (ex1_valid && i_tlb_miss && (o_perf_tlb_miss != '1))
            o_perf_tlb_miss <= o_perf_tlb_miss + 32'd1;
         if (ex2_valid && (i_l1d_miss | i_l1d_conflict) && (o_perf_l1d_miss != '1))
            o_perf_l1d_miss <= o_perf_l1d_miss + 32'd1;
         if (o_ex0_conflict && (o_perf_conflict != '1))
            o_perf_conflict <= o_perf_conflict + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_msrh_lsu_ld_pipe_gen.sv
// Scoreboard bench for msrh_lsu_ld_pipe_gen: pregenerated per-cycle stimulus, expected events queued at issue.
module tb_msrh_lsu_ld_pipe_gen;

   localparam int NC = 400;

   typedef struct {
      bit          v;
      logic [63:0] rs1;
      logic [11:0] imm;
      logic [1:0]  size;
      bit          sgn;
      logic [6:0]  rnid;
      logic [4:0]  tag;
   } op_t;

   typedef struct {
      int          cyc;
      logic [4:0]  tag;
      logic [1:0]  haz;
      logic [38:0] va;
      bit          l1v;
      logic [55:0] pa;
      logic [6:0]  rnid;
      logic [63:0] data;
   } exp_t;

   logic         clk = 1'b0;
   logic         i_reset;
   logic         i_rs_valid, i_rs_signed, i_rp_valid, i_rp_signed;
   logic [63:0]  i_rs_rs1, i_rp_rs1;
   logic [11:0]  i_rs_imm, i_rp_imm;
   logic [1:0]   i_rs_size, i_rp_size;
   logic [6:0]   i_rs_rnid, i_rp_rnid;
   logic [4:0]   i_rs_tag, i_rp_tag;
   logic         o_ex0_conflict;
   logic [4:0]   o_ex0_conflict_tag;
   logic         i_flush;
   logic [38:0]  o_tlb_vaddr;
   logic         i_tlb_miss;
   logic [55:0]  i_tlb_paddr;
   logic         o_l1d_valid;
   logic [55:0]  o_l1d_paddr;
   logic         i_l1d_hit, i_l1d_miss, i_l1d_conflict;
   logic [127:0] i_l1d_data;
   logic         o_ex1_upd_valid, o_ex2_upd_valid;
   logic [4:0]   o_ex1_upd_tag, o_ex2_upd_tag;
   logic [1:0]   o_ex1_upd_haz, o_ex2_upd_haz;
   logic [55:0]  o_ex2_miss_paddr;
   logic         o_ex3_wr_valid, o_ex3_done;
   logic [6:0]   o_ex3_wr_rnid;
   logic [63:0]  o_ex3_wr_data;
`ifdef MSRH_LSU_LD_PIPE_PERF_EN
   logic [31:0]  o_perf_done, o_perf_tlb_miss, o_perf_l1d_miss, o_perf_conflict;
`endif

   msrh_lsu_ld_pipe_gen dut (
      .i_clk(clk), .i_reset(i_reset),
      .i_rs_valid(i_rs_valid), .i_rs_rs1(i_rs_rs1), .i_rs_imm(i_rs_imm), .i_rs_size(i_rs_size),
      .i_rs_signed(i_rs_signed), .i_rs_rnid(i_rs_rnid), .i_rs_tag(i_rs_tag),
      .i_rp_valid(i_rp_valid), .i_rp_rs1(i_rp_rs1), .i_rp_imm(i_rp_imm), .i_rp_size(i_rp_size),
      .i_rp_signed(i_rp_signed), .i_rp_rnid(i_rp_rnid), .i_rp_tag(i_rp_tag),
      .o_ex0_conflict(o_ex0_conflict), .o_ex0_conflict_tag(o_ex0_conflict_tag),
      .i_flush(i_flush), .o_tlb_vaddr(o_tlb_vaddr), .i_tlb_miss(i_tlb_miss), .i_tlb_paddr(i_tlb_paddr),
      .o_l1d_valid(o_l1d_valid), .o_l1d_paddr(o_l1d_paddr),
      .i_l1d_hit(i_l1d_hit), .i_l1d_miss(i_l1d_miss), .i_l1d_conflict(i_l1d_conflict), .i_l1d_data(i_l1d_data),
      .o_ex1_upd_valid(o_ex1_upd_valid), .o_ex1_upd_tag(o_ex1_upd_tag), .o_ex1_upd_haz(o_ex1_upd_haz),
      .o_ex2_upd_valid(o_ex2_upd_valid), .o_ex2_upd_tag(o_ex2_upd_tag), .o_ex2_upd_haz(o_ex2_upd_haz),
      .o_ex2_miss_paddr(o_ex2_miss_paddr),
      .o_ex3_wr_valid(o_ex3_wr_valid), .o_ex3_wr_rnid(o_ex3_wr_rnid), .o_ex3_wr_data(o_ex3_wr_data),
      .o_ex3_done(o_ex3_done)
`ifdef MSRH_LSU_LD_PIPE_PERF_EN
      , .o_perf_done(o_perf_done), .o_perf_tlb_miss(o_perf_tlb_miss),
      .o_perf_l1d_miss(o_perf_l1d_miss), .o_perf_conflict(o_perf_conflict)
`endif
   );

   always #5 clk = ~clk;

   op_t          rs_a [NC];
   op_t          rp_a [NC];
   bit           fl_a [NC];
   bit           tm_a [NC];
   bit           hit_a [NC];
   bit           miss_a [NC];
   bit           cf_a [NC];
   logic [55:0]  pa_a [NC];
   logic [127:0] ln_a [NC];

   exp_t q1[$], q2[$], q3[$];
   int   n_checks = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   run = 1'b0;
   int   exp_done = 0, exp_tlb = 0, exp_l1d = 0, exp_conf = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [38:0] vaddr_of(input op_t o);
      return o.rs1[38:0] + {{27{o.imm[11]}}, o.imm};
   endfunction

   // Little-endian bytes from the line starting at off, zero/sign extended to 64 bits
   function automatic logic [63:0] load_value(input logic [127:0] line, input int off, input int size, input bit sgn);
      int n = 1 << size;
      logic [63:0] v = 64'd0;
      for (int k = 0; k < n; k++)
         if (off + k < 16) v = v | (64'(line[8*(off+k) +: 8]) << (8*k));
      if (sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      return v;
   endfunction

   function automatic op_t rand_op(input bit v);
      op_t o;
      bit  al = ($urandom_range(0, 3) != 0);
      o.v    = v;
      o.size = 2'($urandom_range(0, 3));
      o.rs1  = {$urandom, $urandom};
      o.imm  = 12'($urandom);
      if (al) begin
         o.rs1 = o.rs1 & ~((64'd1 << o.size) - 64'd1);
         o.imm = o.imm & ~((12'd1 << o.size) - 12'd1);
      end
      o.sgn  = 1'($urandom);
      o.rnid = 7'($urandom);
      o.tag  = 5'($urandom);
      return o;
   endfunction

   function automatic op_t mk_op(input logic [63:0] rs1, input logic [11:0] imm, input logic [1:0] size,
                                 input bit sgn, input logic [6:0] rnid, input logic [4:0] tag);
      op_t o;
      o.v = 1'b1; o.rs1 = rs1; o.imm = imm; o.size = size; o.sgn = sgn; o.rnid = rnid; o.tag = tag;
      return o;
   endfunction

   // Model: the fate of the op issued in cycle c follows from that cycle's and later cycles' stimulus
   task automatic issue_expect(input int c);
      op_t  s;
      exp_t e;
      int   haz1, haz2;
      if (rs_a[c].v && rp_a[c].v) exp_conf++;
      if (!(rs_a[c].v || rp_a[c].v) || fl_a[c]) return;
      s = rp_a[c].v ? rp_a[c] : rs_a[c];
      e.va   = vaddr_of(s);
      haz1   = tm_a[c+1] ? 1 : ((e.va % (39'd1 << s.size)) != 0) ? 2 : 0;
      e.cyc  = c + 1;
      e.tag  = s.tag;
      e.haz  = 2'(haz1);
      e.l1v  = (haz1 == 0) && !fl_a[c+1];
      e.pa   = pa_a[c+1] & ~56'hF;
      e.rnid = s.rnid;
      e.data = 64'd0;
      q1.push_back(e);
      if (haz1 == 1) exp_tlb++;
      if (haz1 != 0 || fl_a[c+1]) return;
      haz2  = cf_a[c+2] ? 2 : miss_a[c+2] ? 1 : 0;
      e.cyc = c + 2;
      e.haz = 2'(haz2);
      e.pa  = pa_a[c+1];
      q2.push_back(e);
      if (haz2 != 0) exp_l1d++;
      if (haz2 != 0 || !hit_a[c+2] || fl_a[c+2]) return;
      e.cyc  = c + 3;
      e.data = load_value(ln_a[c+2], int'(pa_a[c+1][3:0]), int'(s.size), s.sgn);
      q3.push_back(e);
      exp_done++;
   endtask

   // Monitor: pops the expected queues whenever the DUT presents a stage event
   always @(negedge clk) begin
      exp_t e;
      if (run) begin
         check("ex0_conflict", o_ex0_conflict, rs_a[cyc].v & rp_a[cyc].v);
         if (rs_a[cyc].v && rp_a[cyc].v) check("ex0_conflict_tag", o_ex0_conflict_tag, rs_a[cyc].tag);
         if (o_ex1_upd_valid) begin
            if (q1.size() == 0) check("ex1_upd_valid", o_ex1_upd_valid, 1'b0);
            else begin
               e = q1.pop_front();
               check("ex1_cycle", cyc, e.cyc);
               check("ex1_tag", o_ex1_upd_tag, e.tag);
               check("ex1_haz", o_ex1_upd_haz, e.haz);
               check("tlb_vaddr", o_tlb_vaddr, e.va);
               check("l1d_valid", o_l1d_valid, e.l1v);
               if (e.l1v) check("l1d_paddr", o_l1d_paddr, e.pa);
            end
         end else begin
            check("l1d_valid_idle", o_l1d_valid, 1'b0);
            if (q1.size() != 0 && q1[0].cyc <= cyc) begin
               check("ex1_upd_valid", o_ex1_upd_valid, 1'b1);
               void'(q1.pop_front());
            end
         end
         if (o_ex2_upd_valid) begin
            if (q2.size() == 0) check("ex2_upd_valid", o_ex2_upd_valid, 1'b0);
            else begin
               e = q2.pop_front();
               check("ex2_cycle", cyc, e.cyc);
               check("ex2_tag", o_ex2_upd_tag, e.tag);
               check("ex2_haz", o_ex2_upd_haz, e.haz);
               check("ex2_miss_paddr", o_ex2_miss_paddr, e.pa);
            end
         end else if (q2.size() != 0 && q2[0].cyc <= cyc) begin
            check("ex2_upd_valid", o_ex2_upd_valid, 1'b1);
            void'(q2.pop_front());
         end
         if (o_ex3_wr_valid) begin
            if (q3.size() == 0) check("ex3_wr_valid", o_ex3_wr_valid, 1'b0);
            else begin
               e = q3.pop_front();
               check("ex3_cycle", cyc, e.cyc);
               check("ex3_rnid", o_ex3_wr_rnid, e.rnid);
               check("ex3_data", o_ex3_wr_data, e.data);
               check("ex3_done", o_ex3_done, 1'b1);
            end
         end else begin
            check("ex3_done_idle", o_ex3_done, 1'b0);
            if (q3.size() != 0 && q3[0].cyc <= cyc) begin
               check("ex3_wr_valid", o_ex3_wr_valid, 1'b1);
               void'(q3.pop_front());
            end
         end
      end
   end

   task automatic drive_cycle(input int c);
      i_rs_valid = rs_a[c].v;  i_rs_rs1 = rs_a[c].rs1; i_rs_imm = rs_a[c].imm; i_rs_size = rs_a[c].size;
      i_rs_signed = rs_a[c].sgn; i_rs_rnid = rs_a[c].rnid; i_rs_tag = rs_a[c].tag;
      i_rp_valid = rp_a[c].v;  i_rp_rs1 = rp_a[c].rs1; i_rp_imm = rp_a[c].imm; i_rp_size = rp_a[c].size;
      i_rp_signed = rp_a[c].sgn; i_rp_rnid = rp_a[c].rnid; i_rp_tag = rp_a[c].tag;
      i_flush = fl_a[c]; i_tlb_miss = tm_a[c]; i_tlb_paddr = pa_a[c];
      i_l1d_hit = hit_a[c]; i_l1d_miss = miss_a[c]; i_l1d_conflict = cf_a[c]; i_l1d_data = ln_a[c];
   endtask

   initial begin
      // Per-cycle stimulus: quiet directed region, random middle, idle tail
      for (int c = 0; c < NC; c++) begin
         bit rnd = (c >= 40) && (c < NC - 6);
         int r   = $urandom_range(0, 19);
         rs_a[c] = rand_op(rnd && ($urandom_range(0, 1) == 1));
         rp_a[c] = rand_op(rnd && ($urandom_range(0, 3) == 0));
         fl_a[c] = rnd && ($urandom_range(0, 31) == 0);
         tm_a[c] = rnd && ($urandom_range(0, 9) == 0);
         hit_a[c] = 1'b1; miss_a[c] = 1'b0; cf_a[c] = 1'b0;
         if (rnd) begin
            if (r == 0)      begin hit_a[c] = 1'b0; miss_a[c] = 1'b1; end
            else if (r == 1) begin hit_a[c] = 1'b0; cf_a[c] = 1'b1; end
            else if (r == 2) begin hit_a[c] = 1'b0; miss_a[c] = 1'b1; cf_a[c] = 1'b1; end
            else if (r == 3) hit_a[c] = 1'b0;
         end
         pa_a[c] = {$urandom, $urandom};
         ln_a[c] = {$urandom, $urandom, $urandom, $urandom};
      end
      rs_a[2]  = mk_op(64'h1000, 12'h004, 2'd2, 1'b1, 7'd1, 5'd1);
      ln_a[4][63:32] = 32'h8000_0001;
      rs_a[6]  = mk_op(64'h1000, 12'h004, 2'd2, 1'b0, 7'd2, 5'd2);
      ln_a[8][63:32] = 32'h8000_0001;
      rs_a[10] = mk_op(64'h1500, 12'h000, 2'd3, 1'b0, 7'd3, 5'd3);
      rp_a[10] = mk_op(64'h2000, 12'h008, 2'd3, 1'b0, 7'd4, 5'd4);
      rs_a[14] = mk_op(64'h1001, 12'h000, 2'd1, 1'b0, 7'd5, 5'd5);
      rs_a[16] = mk_op(64'h1001, 12'h000, 2'd1, 1'b0, 7'd6, 5'd6);
      tm_a[17] = 1'b1;
      rs_a[18] = mk_op(64'h3000, 12'h010, 2'd2, 1'b0, 7'd7, 5'd7);
      hit_a[20] = 1'b0; miss_a[20] = 1'b1; cf_a[20] = 1'b1;
      rs_a[21] = mk_op(64'h3000, 12'hFF0, 2'd2, 1'b0, 7'd8, 5'd8);
      hit_a[23] = 1'b0; miss_a[23] = 1'b1;
      rs_a[25] = mk_op(64'h4000, 12'h000, 2'd3, 1'b0, 7'd9, 5'd9);
      rs_a[26] = mk_op(64'h4008, 12'h000, 2'd3, 1'b0, 7'd10, 5'd10);
      rs_a[27] = mk_op(64'h4010, 12'h000, 2'd3, 1'b0, 7'd11, 5'd11);
      fl_a[28] = 1'b1;
      rs_a[31] = mk_op(64'h0000_007F_FFFF_FFFF, 12'h001, 2'd0, 1'b1, 7'd12, 5'd12);
      // Physical page offset follows the virtual one
      for (int c = 0; c < NC - 1; c++)
         if (rs_a[c].v || rp_a[c].v)
            pa_a[c+1][11:0] = vaddr_of(rp_a[c].v ? rp_a[c] : rs_a[c])[11:0];

      i_reset = 1'b1;
      drive_cycle(0);
      i_rs_valid = 1'b0; i_rp_valid = 1'b0; i_flush = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ex1_valid", o_ex1_upd_valid, 1'b0);
      check("rst_ex2_valid", o_ex2_upd_valid, 1'b0);
      check("rst_ex3_valid", o_ex3_wr_valid, 1'b0);
      check("rst_l1d_valid", o_l1d_valid, 1'b0);
      check("rst_ex3_data", o_ex3_wr_data, 64'd0);
      check("rst_miss_paddr", o_ex2_miss_paddr, 56'd0);
      i_reset = 1'b0;

      for (int c = 0; c < NC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         drive_cycle(c);
         issue_expect(c);
         run = 1'b1;
      end
      @(negedge clk);
      #1;
      run = 1'b0;

`ifdef MSRH_LSU_LD_PIPE_PERF_EN
      check("perf_done", o_perf_done, exp_done);
      check("perf_tlb_miss", o_perf_tlb_miss, exp_tlb);
      check("perf_l1d_miss", o_perf_l1d_miss, exp_l1d);
      check("perf_conflict", o_perf_conflict, exp_conf);
`endif

      // Reset arriving while a load sits in EX2 discards it immediately
      @(posedge clk); #1;
      i_rs_valid = 1'b1; i_rp_valid = 1'b0; i_flush = 1'b0; i_tlb_miss = 1'b0;
      i_rs_rs1 = 64'h3000; i_rs_imm = 12'h000; i_rs_size = 2'd3;
      i_l1d_hit = 1'b1; i_l1d_miss = 1'b0; i_l1d_conflict = 1'b0;
      @(posedge clk); #1;
      i_rs_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_ex2_valid", o_ex2_upd_valid, 1'b1);
      #2 i_reset = 1'b1;
      #1;
      check("mid_reset_ex1_valid", o_ex1_upd_valid, 1'b0);
      check("mid_reset_ex2_valid", o_ex2_upd_valid, 1'b0);
      check("mid_reset_ex3_valid", o_ex3_wr_valid, 1'b0);
      check("mid_reset_miss_paddr", o_ex2_miss_paddr, 56'd0);
`ifdef MSRH_LSU_LD_PIPE_PERF_EN
      check("mid_reset_perf_done", o_perf_done, 32'd0);
`endif
      @(posedge clk); #1;
      i_reset = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/msrh_lsu_ld_pipe_gen.md
Name: msrh_lsu_ld_pipe_gen

Overview:
Parametrised 4-stage (EX0–EX3) load pipeline for one LSU lane.
- EX0: arbitrates replay vs. reservation-station issue.
- EX1: computes vaddr and queries the TLB.
- EX2: checks L1D hit/miss/conflict and reports hazards to the load queue.
- EX3: writes back size-aligned, sign/zero-extended data.
- Generalises the fixed 8-byte load lane: configurable XLEN, cache line width and tag width; B/H/W/D sizes; misalignment detection; pipeline flush.

Parameters:
XLEN_W, 64, register/data width (32 or 64)
VADDR_W, 39, virtual address width
PADDR_W, 56, physical address width
LINE_W, 128, L1D read data width in bits (power of 2, >= XLEN_W)
RNID_W, 7, physical register id width
TAG_W, 5, load queue / commit tag width

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_rs_valid  in  1  RS issue valid (no backpressure)
i_rs_rs1  in  XLEN_W  base register value
i_rs_imm  in  12  signed offset
i_rs_size  in  2  0=B 1=H 2=W 3=D
i_rs_signed  in  1  sign-extend result
i_rs_rnid  in  RNID_W  destination register
i_rs_tag  in  TAG_W  queue/commit tag
i_rp_valid, i_rp_rs1, i_rp_imm, i_rp_size, i_rp_signed, i_rp_rnid, i_rp_tag  in  as above  replay issue
o_ex0_conflict  out  1  RS issue dropped this cycle
o_ex0_conflict_tag  out  TAG_W  tag of dropped RS issue
i_flush  in  1  kill all in-flight ops
o_tlb_vaddr  out  VADDR_W  EX1 TLB lookup address
i_tlb_miss  in  1  EX1 TLB miss (same cycle)
i_tlb_paddr  in  PADDR_W  EX1 translated address
o_l1d_valid  out  1  EX1 L1D read request
o_l1d_paddr  out  PADDR_W  line-aligned paddr
i_l1d_hit, i_l1d_miss, i_l1d_conflict  in  1  EX2 cache result
i_l1d_data  in  LINE_W  EX2 line data
o_ex1_upd_valid  out  1  EX1 queue update
o_ex1_upd_tag  out  TAG_W  tag
o_ex1_upd_haz  out  2  0=NONE 1=TLB_MISS 2=MISALIGN
o_ex2_upd_valid  out  1  EX2 queue update
o_ex2_upd_tag  out  TAG_W  tag
o_ex2_upd_haz  out  2  0=NONE 1=L1D_MISS 2=L1D_CONFLICT
o_ex2_miss_paddr  out  PADDR_W  refill request address
o_ex3_wr_valid  out  1  register writeback
o_ex3_wr_rnid  out  RNID_W  destination
o_ex3_wr_data  out  XLEN_W  aligned, extended load data
o_ex3_done  out  1  load completed

Behaviour:
- Reset: all stage valids, all outputs and all counters = 0. Reset asserted mid-operation discards every stage immediately.
- EX0 arbitration:
  - Replay has priority. Selected op = i_rp_* when i_rp_valid, else i_rs_*.
  - o_ex0_conflict = i_rs_valid & i_rp_valid, combinational; o_ex0_conflict_tag = i_rs_tag. The RS must re-issue the dropped op.
  - Selected op is registered into EX1 (1-cycle latency).
- EX1 address and TLB:
  - vaddr = rs1[VADDR_W-1:0] + sign-extended imm, modulo 2^VADDR_W (wrap, no overflow flag).
  - misalign = 1 when vaddr is not a multiple of (1<<size).
  - o_l1d_valid = ex1_valid & !i_tlb_miss & !misalign & !i_flush.
  - o_l1d_paddr = i_tlb_paddr with the low log2(LINE_W/8) bits cleared.
  - o_ex1_upd_valid = ex1_valid. o_ex1_upd_haz = TLB_MISS if i_tlb_miss, else MISALIGN if misalign, else NONE; TLB_MISS wins when both are set.
  - Op advances to EX2 only when o_ex1_upd_haz = NONE.
- EX2 cache check:
  - Registers full paddr, size and signed from EX1.
  - o_ex2_upd_valid = ex2_valid. Haz = L1D_CONFLICT if i_l1d_conflict, else L1D_MISS if i_l1d_miss, else NONE; conflict wins.
  - o_ex2_miss_paddr = registered paddr.
  - Advances to EX3 only when i_l1d_hit and haz = NONE. Data extraction happens here and is registered into EX3.
- Data extraction:
  - byte_off = paddr[log2(LINE_W/8)-1:0]; raw = i_l1d_data >> (8*byte_off).
  - Take the low 8/16/32/64 bits per size, then sign- or zero-extend to XLEN_W.
  - size=3 with XLEN_W=32 is treated as MISALIGN in EX1.
- EX3 writeback:
  - o_ex3_done = ex3_valid; o_ex3_wr_valid = ex3_valid.
  - o_ex3_wr_rnid and o_ex3_wr_data are held from the register stage.
  - Total latency from EX0 issue to writeback is 3 cycles.
- Flush: i_flush clears EX1/EX2/EX3 valids at the next edge and gates o_l1d_valid in the same cycle. EX0 ops presented during flush are discarded. Queue update outputs still reflect the current-cycle state.
- Back-to-back issue every cycle is supported; there are no internal stalls.

Optional Feature:
MSRH_LSU_LD_PIPE_PERF_EN:
- Defined: adds 32-bit saturating counters o_perf_done, o_perf_tlb_miss, o_perf_l1d_miss, o_perf_conflict. Each increments on the respective event: ex3 done, EX1 TLB_MISS, EX2 L1D_MISS or L1D_CONFLICT, o_ex0_conflict. Counters hold at 0xFFFFFFFF and clear on reset.
- Undefined: these ports and counters are absent.

Test Plan:
- RS load size=W signed, rs1=0x1000, imm=0x004, line data bytes 4..7 = 0x80000001, TLB/L1D hit -> o_ex3_wr_valid exactly 3 cycles later with data 0xFFFFFFFF80000001; the same load unsigned -> 0x0000000080000001.
- i_rs_valid and i_rp_valid in the same cycle -> replay op reaches EX1, o_ex0_conflict=1 with RS tag, RS op never writes back.
- rs1=0x1001, imm=0, size=H -> o_ex1_upd_haz=MISALIGN, o_l1d_valid=0, no EX2/EX3 activity; the same op with i_tlb_miss=1 -> haz=TLB_MISS.
- EX2 with i_l1d_miss=1 and i_l1d_conflict=1 -> haz=L1D_CONFLICT, o_ex2_miss_paddr = full paddr, no writeback; miss alone -> L1D_MISS.
- Three back-to-back hits, then i_flush asserted while the 2nd op is in EX2 -> only the 1st op writes back; the 2nd and 3rd are killed.
- vaddr wrap: rs1 = all-ones (VADDR_W bits), imm=+1, size=B -> vaddr=0, no misalign. With PERF_EN defined, 5 hits -> o_perf_done=5.
